// File: rtl/bcd_updown_pkg.sv
// Shared types and seven-segment glyphs for the BCD up/down display counter.
// Glyphs are active-low, bit 0 = segment A through bit 6 = segment G.
package bcd_updown_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] i_digit);
    case (i_digit)
      4'd0:    bcd_glyph = SEG_0;
      4'd1:    bcd_glyph = SEG_1;
      4'd2:    bcd_glyph = SEG_2;
      4'd3:    bcd_glyph = SEG_3;
      4'd4:    bcd_glyph = SEG_4;
      4'd5:    bcd_glyph = SEG_5;
      4'd6:    bcd_glyph = SEG_6;
      4'd7:    bcd_glyph = SEG_7;
      4'd8:    bcd_glyph = SEG_8;
      4'd9:    bcd_glyph = SEG_9;
      default: bcd_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Registered single-digit BCD to active-low seven-segment decoder with blanking.
module bcd_seg7_decode
  import bcd_updown_pkg::*;
#(
  parameter bit RST_BLANK = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Digit,
  input  logic       i_Blank,
  output logic [6:0] o_Seg
);

  logic [6:0] r_seg;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_seg <= RST_BLANK ? SEG_BLANK : SEG_0;
    else          r_seg <= i_Blank ? SEG_BLANK : bcd_glyph(i_Digit);
  end

  assign o_Seg = r_seg;

endmodule

// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with press-and-hold auto-repeat and registered
// seven-segment outputs. Define BCD_UPDOWN_BLANK_LEADING_EN to blank leading zeros.
module bcd_updown_display
  import bcd_updown_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int HOLD_CLKS   = 12_500_000,
  parameter int REPEAT_CLKS = 2_500_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Inc,
  input  logic                  i_Dec,
  input  logic                  i_Clear,
  output logic [4*DIGITS-1:0]   o_Value,
  output logic [7*DIGITS-1:0]   o_Segments,
  output logic                  o_Wrap
);

  localparam int MAX_CLKS = (HOLD_CLKS > REPEAT_CLKS) ? HOLD_CLKS : REPEAT_CLKS;
  localparam int TMR_W    = $clog2(MAX_CLKS);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CLKS - 1);
  localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CLKS - 1);
`ifdef BCD_UPDOWN_BLANK_LEADING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [4*DIGITS-1:0] r_value;
  logic                r_wrap;
  state_e              r_state;
  dir_e                r_dir;
  logic [TMR_W-1:0]    r_timer;
  logic                r_inc, r_inc_d, r_inc_lk;
  logic                r_dec, r_dec_d, r_dec_lk;

  // A button held through reset keeps its lock set, so its previous-sample
  // stays 1 until it is released and a fresh press is required.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_inc <= 1'b0; r_inc_d <= 1'b1; r_inc_lk <= 1'b1;
      r_dec <= 1'b0; r_dec_d <= 1'b1; r_dec_lk <= 1'b1;
    end else begin
      r_inc <= i_Inc; r_inc_d <= r_inc | r_inc_lk; r_inc_lk <= r_inc_lk & i_Inc;
      r_dec <= i_Dec; r_dec_d <= r_dec | r_dec_lk; r_dec_lk <= r_dec_lk & i_Dec;
    end
  end

  logic w_inc_press, w_dec_press, w_latched;
  assign w_inc_press = r_inc & ~r_inc_d;
  assign w_dec_press = r_dec & ~r_dec_d;
  assign w_latched   = (r_dir == DIR_UP) ? r_inc : r_dec;

  logic [4*DIGITS-1:0] w_val_up, w_val_dn, w_step_val;
  logic                w_carry, w_borrow, w_step_wrap;
  dir_e                w_step_dir;

  // NOTE: blocking assignments here are intentional: carry/borrow ripple
  // digit to digit within a single evaluation of the loop.
  always_comb begin
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    w_val_up = r_value;
    w_val_dn = r_value;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_value[4*d +: 4] == 4'd9) w_val_up[4*d +: 4] = 4'd0;
        else begin
          w_val_up[4*d +: 4] = r_value[4*d +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_value[4*d +: 4] == 4'd0) w_val_dn[4*d +: 4] = 4'd9;
        else begin
          w_val_dn[4*d +: 4] = r_value[4*d +: 4] - 4'd1;
          w_borrow = 1'b0;
        end
      end
    end
  end

  assign w_step_dir  = (r_state == IDLE) ? (w_dec_press ? DIR_DOWN : DIR_UP) : r_dir;
  assign w_step_val  = (w_step_dir == DIR_UP) ? w_val_up : w_val_dn;
  assign w_step_wrap = (w_step_dir == DIR_UP) ? w_carry  : w_borrow;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_timer <= '0;
    end else if (i_Clear) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (r_inc && r_dec) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_inc_press || w_dec_press) begin
              r_value <= w_step_val;
              r_wrap  <= w_step_wrap;
              r_dir   <= w_step_dir;
              r_timer <= HOLD_LOAD;
              r_state <= HOLD;
            end
          end
          HOLD, REPEAT: begin
            if (!w_latched) begin
              r_state <= IDLE;
              r_timer <= '0;
            end else if (r_timer == '0) begin
              r_value <= w_step_val;
              r_wrap  <= w_step_wrap;
              r_timer <= REPEAT_LOAD;
              r_state <= REPEAT;
            end else begin
              r_timer <= r_timer - TMR_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Digit d is blanked when it and every digit above it are zero; digit 0 never.
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_zero_above = w_zero_above & (r_value[4*d +: 4] == 4'd0);
      w_blank[d]   = BLANK_EN & w_zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_seg7_decode #(
      .RST_BLANK (BLANK_EN && (g > 0))
    ) u_dec (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Digit (r_value[4*g +: 4]),
      .i_Blank (w_blank[g]),
      .o_Seg   (o_Segments[7*g +: 7])
    );
  end

  assign o_Value = r_value;
  assign o_Wrap  = r_wrap;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed self-checking bench for bcd_updown_display (DIGITS=2, short hold/repeat).
module tb_bcd_updown_display;

  localparam int DIGITS = 2;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GB = 7'b1111111;
`ifdef BCD_UPDOWN_BLANK_LEADING_EN
  localparam logic [6:0] LEAD0 = GB;
`else
  localparam logic [6:0] LEAD0 = G0;
`endif

  logic        clk = 1'b0;
  logic        rst_l, inc, dec, clr;
  logic [7:0]  value;
  logic [13:0] segs;
  logic        wrap;
  int          n_pass = 0;
  int          n_total = 0;

  bcd_updown_display #(
    .DIGITS      (DIGITS),
    .HOLD_CLKS   (10),
    .REPEAT_CLKS (4)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_l),
    .i_Inc      (inc),
    .i_Dec      (dec),
    .i_Clear    (clr),
    .o_Value    (value),
    .o_Segments (segs),
    .o_Wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Press one button for one sample; returns just after the edge that steps.
  task automatic pulse(input logic up);
    if (up) inc = 1'b1; else dec = 1'b1;
    step(1);
    inc = 1'b0;
    dec = 1'b0;
    step(1);
  endtask

  initial begin
    rst_l = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    step(3);
    rst_l = 1'b1;
    step(1);
    check("reset_value", 32'(value), 32'h00);
    check("reset_segs",  32'(segs),  32'({LEAD0, G0}));
    check("reset_wrap",  32'(wrap),  32'h0);

    // Count up to 09 with single presses, then the carry into digit 1.
    for (int i = 0; i < 9; i++) begin
      pulse(1'b1);
      step(1);
    end
    check("count_09", 32'(value), 32'h09);
    inc = 1'b1;
    step(1);
    check("no_step_at_k", 32'(value), 32'h09);
    inc = 1'b0;
    step(1);
    check("carry_10_k1", 32'(value), 32'h10);
    check("segs_still_09_k1", 32'(segs), 32'({LEAD0, G9}));
    check("no_wrap_carry", 32'(wrap), 32'h0);
    step(1);
    check("segs_10_k2", 32'(segs), 32'({G1, G0}));

    pulse(1'b0);
    check("borrow_09", 32'(value), 32'h09);
    step(1);

    // Clear, then wrap downward and upward.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clear_value", 32'(value), 32'h00);
    pulse(1'b0);
    check("dec_wrap_value", 32'(value), 32'h99);
    check("dec_wrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("dec_wrap_one_cycle", 32'(wrap), 32'h0);
    check("segs_99", 32'(segs), 32'({G9, G9}));
    pulse(1'b1);
    check("inc_wrap_value", 32'(value), 32'h00);
    check("inc_wrap_pulse", 32'(wrap), 32'h1);
    step(1);
    check("inc_wrap_one_cycle", 32'(wrap), 32'h0);
    step(1);

    // Press-and-hold: steps at k+1, k+11, k+15, k+19, k+23, k+27.
    inc = 1'b1;
    step(2);
    check("hold_first_step", 32'(value), 32'h01);
    step(9);
    check("hold_not_early", 32'(value), 32'h01);
    step(1);
    check("hold_first_auto", 32'(value), 32'h02);
    step(3);
    check("repeat_not_early", 32'(value), 32'h02);
    step(1);
    check("repeat_step", 32'(value), 32'h03);
    step(12);
    check("repeat_final_06", 32'(value), 32'h06);
    inc = 1'b0;
    step(10);
    check("release_no_steps", 32'(value), 32'h06);

    // Both buttons rising together: no step.
    inc = 1'b1; dec = 1'b1;
    step(5);
    check("both_no_step", 32'(value), 32'h06);
    check("both_no_wrap", 32'(wrap), 32'h0);
    inc = 1'b0; dec = 1'b0;
    step(2);

    // Clear during REPEAT with button still held.
    inc = 1'b1;
    step(16);
    check("repeat_to_09", 32'(value), 32'h09);
    clr = 1'b1;
    step(1);
    check("clear_in_repeat", 32'(value), 32'h00);
    check("clear_no_wrap", 32'(wrap), 32'h0);
    step(6);
    check("held_clear_suppresses", 32'(value), 32'h00);
    clr = 1'b0;
    step(5);
    check("after_clear_needs_press", 32'(value), 32'h00);
    inc = 1'b0;
    step(2);

    // Reset mid-HOLD with button held: no step until a fresh press.
    inc = 1'b1;
    step(2);
    check("press_before_reset", 32'(value), 32'h01);
    step(3);
    rst_l = 1'b0;
    step(2);
    rst_l = 1'b1;
    step(15);
    check("reset_held_no_step", 32'(value), 32'h00);
    inc = 1'b0;
    step(2);
    pulse(1'b1);
    check("fresh_press_after_reset", 32'(value), 32'h01);
    step(1);

    // Leading-zero display at 05.
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1);
      step(1);
    end
    check("value_05", 32'(value), 32'h05);
    check("segs_05", 32'(segs), 32'({LEAD0, G5}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
